// File: rtl/fe_fifo_reader.sv
// Read side of the front-end capture FIFO: pops entries and
// serialises each one into a header + payload byte stream.
module fe_fifo_reader #(
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int pDATA_WIDTH            = 8
) (
    input  logic                                               cwusb_clk,
    input  logic                                               reset_i,
    input  logic [pTIMESTAMP_FULL_WIDTH+pDATA_WIDTH+1:0]       I_fifo_dout,
    input  logic                                               I_fifo_empty,
    output logic                                               O_fifo_rd,
    input  logic                                               I_flush,
    output logic [7:0]                                         O_byte,
    output logic                                               O_byte_valid,
    input  logic                                               I_byte_ready,
    output logic                                               O_idle,
    output logic [15:0]                                        O_entry_count,
    output logic                                               O_underflow
);

    localparam int TW = pTIMESTAMP_FULL_WIDTH;
    localparam int SW = pTIMESTAMP_SHORT_WIDTH;
    localparam int TB = TW / 8;
    localparam int MSB = TW + pDATA_WIDTH + 1;
    localparam logic [2:0] TIME_BYTES = 3'(1 + TB);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND
    } state_t;

    state_t state;
    logic [1:0] cmd;
    logic [TW-1:0] tstamp;
    logic [7:0] data;
    logic [1:0] idx;
    logic [2:0] count;
    logic [2:0] load_count;
    logic [5:0] short_ts;
    logic [7:0] byte_mux;
    logic last;

    always_comb begin
        unique case (I_fifo_dout[MSB:MSB-1])
            2'd0, 2'd1: load_count = 3'd2;
            2'd2:       load_count = TIME_BYTES;
            default:    load_count = 3'd1;
        endcase
    end

    assign last = ({1'b0, idx} == count - 3'd1);

    // Header, then data byte (DATA/STAT) or timestamp MSB-first (TIME).
    always_comb begin
        short_ts = '0;
        short_ts[SW-1:0] = tstamp[SW-1:0];
        byte_mux = 8'h00;
        if (idx == 2'd0) begin
            if (!cmd[1])
                byte_mux = {cmd, short_ts};
            else
                byte_mux = {cmd, 6'b0};
        end else if (!cmd[1]) begin
            byte_mux = data;
        end else begin
            for (int k = 1; k <= TB; k++)
                if (int'(idx) == k)
                    byte_mux = tstamp[(TB-k)*8 +: 8];
        end
    end

    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            cmd           <= '0;
            tstamp        <= '0;
            data          <= '0;
            idx           <= '0;
            count         <= '0;
            O_entry_count <= '0;
            O_underflow   <= 1'b0;
        end else if (I_flush) begin
            // Any in-flight entry, including a read issued in FETCH, is dropped.
            state         <= IDLE;
            idx           <= '0;
            O_entry_count <= '0;
            O_underflow   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!I_fifo_empty)
                        state <= FETCH;
                end
                FETCH: begin
                    if (I_fifo_empty)
                        O_underflow <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    cmd    <= I_fifo_dout[MSB:MSB-1];
                    tstamp <= I_fifo_dout[MSB-2:pDATA_WIDTH];
                    data   <= I_fifo_dout[7:0];
                    idx    <= '0;
                    count  <= load_count;
                    if (O_entry_count != 16'hFFFF)
                        O_entry_count <= O_entry_count + 16'd1;
                    state <= SEND;
                end
                SEND: begin
                    if (I_byte_ready) begin
                        if (last)
                            state <= I_fifo_empty ? IDLE : FETCH;
                        else
                            idx <= idx + 2'd1;
                    end
                end
            endcase
        end
    end

    assign O_fifo_rd    = (state == FETCH);
    assign O_byte_valid = (state == SEND);
    assign O_byte       = (state == SEND) ? byte_mux : 8'h00;
    assign O_idle       = (state == IDLE) && I_fifo_empty;

endmodule

// File: tb/tb_fe_fifo_reader.sv
// Scoreboard bench for fe_fifo_reader: FIFO model, byte-level
// reference model, randomized ready and entry stream.
module tb_fe_fifo_reader;

    localparam int TW = 16;
    localparam int SW = 3;
    localparam int EW = 2 + TW + 8;

    logic clk = 1'b0;
    logic rst;
    logic [EW-1:0] dout = '0;
    logic empty, rd, flush, ready;
    logic [7:0] obyte;
    logic valid, idle, uflow;
    logic [15:0] cnt;

    always #5 clk = ~clk;

    fe_fifo_reader #(
        .pTIMESTAMP_FULL_WIDTH(TW),
        .pTIMESTAMP_SHORT_WIDTH(SW),
        .pDATA_WIDTH(8)
    ) dut (
        .cwusb_clk(clk),
        .reset_i(rst),
        .I_fifo_dout(dout),
        .I_fifo_empty(empty),
        .O_fifo_rd(rd),
        .I_flush(flush),
        .O_byte(obyte),
        .O_byte_valid(valid),
        .I_byte_ready(ready),
        .O_idle(idle),
        .O_entry_count(cnt),
        .O_underflow(uflow)
    );

    // FIFO model: one-cycle read latency, flag can be forced empty
    logic [EW-1:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic force_empty = 1'b0;
    assign empty = force_empty || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd && rd_ptr != wr_ptr) begin
            dout   <= mem[rd_ptr % 1024];
            rd_ptr <= rd_ptr + 1;
        end
    end

    logic [7:0] exp_q [$];
    int n_chk = 0;
    int n_fail = 0;
    int rd_pulses = 0;
    logic rdy_rand = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Reference model: the byte sequence an entry must produce
    task automatic push(input int c, input int t, input int d);
        mem[wr_ptr % 1024] = {2'(c), TW'(t), 8'(d)};
        wr_ptr = wr_ptr + 1;
        if (c < 2) begin
            exp_q.push_back(8'(c * 64 + t % (1 << SW)));
            exp_q.push_back(8'(d));
        end else if (c == 2) begin
            exp_q.push_back(8'h80);
            for (int i = TW / 8 - 1; i >= 0; i--)
                exp_q.push_back(8'((t >> (8 * i)) & 255));
        end else begin
            exp_q.push_back(8'hC0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!valid && n < 50) begin
            tick();
            n++;
        end
        chk(nm, 32'(valid), 32'd1);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (!(exp_q.size() == 0 && idle) && n < 5000) begin
            tick();
            n++;
        end
        chk(nm, 32'(exp_q.size() == 0 && idle), 32'd1);
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_rand)
            ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops the scoreboard on every transfer, checks stall stability
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic pf = 1'b0;
    logic [7:0] pb = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd)
                rd_pulses++;
            if (pv && !pr && !pf) begin
                chk("stall_valid", 32'(valid), 32'd1);
                chk("stall_byte", 32'(obyte), 32'(pb));
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL stream: got %0h, expected no byte", obyte);
                end else begin
                    chk("stream", 32'(obyte), 32'(exp_q.pop_front()));
                end
            end
        end
        pv <= valid && !rst;
        pr <= ready;
        pf <= flush;
        pb <= obyte;
    end

    initial begin
        int lat;
        int base;
        int pushed;
        rst = 1'b1;
        flush = 1'b0;
        ready = 1'b1;
        #12;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_byte", 32'(obyte), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_uflow", 32'(uflow), 32'd0);
        chk("rst_idle", 32'(idle), 32'(empty));
        @(negedge clk);
        rst = 1'b0;

        // single DATA entry
        tick();
        base = rd_pulses;
        push(0, 16'h0005, 8'hA7);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!valid && lat < 20);
        chk("t1_latency", 32'(lat), 32'd3);
        tick();
        chk("t1_second", 32'(valid), 32'd1);
        tick();
        chk("t1_done", 32'(valid), 32'd0);
        chk("t1_idle", 32'(idle), 32'd1);
        chk("t1_count", 32'(cnt), 32'd1);
        chk("t1_rd", 32'(rd_pulses - base), 32'd1);

        // TIME entry with backpressure
        ready = 1'b0;
        base = rd_pulses;
        push(2, 16'h1234, 0);
        wait_valid("t2_valid");
        for (int i = 0; i < 5; i++) begin
            ready = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            tick();
        end
        chk("t2_done", 32'(valid), 32'd0);
        chk("t2_drained", 32'(exp_q.size()), 32'd0);
        chk("t2_rd", 32'(rd_pulses - base), 32'd1);
        chk("t2_count", 32'(cnt), 32'd2);

        flush = 1'b1;
        tick();
        chk("flush_count", 32'(cnt), 32'd0);
        flush = 1'b0;

        // burst of random entries with random ready
        rdy_rand = 1'b1;
        base = rd_pulses;
        pushed = 0;
        while (pushed < 100) begin
            tick();
            if ($urandom_range(0, 1) == 1) begin
                push($urandom_range(0, 3), $urandom_range(0, 65535),
                     $urandom_range(0, 255));
                pushed++;
            end
        end
        drain("t3_drain");
        rdy_rand = 1'b0;
        tick();
        chk("t3_count", 32'(cnt), 32'd100);
        chk("t3_rd", 32'(rd_pulses - base), 32'd100);

        // flush mid-entry
        ready = 1'b0;
        push(2, 16'hABCD, 0);
        wait_valid("t4_valid");
        ready = 1'b1;
        tick();
        flush = 1'b1;
        ready = 1'b0;
        exp_q.delete();
        tick();
        chk("t4_drop", 32'(valid), 32'd0);
        chk("t4_count", 32'(cnt), 32'd0);
        tick();
        chk("t4_hold", 32'(valid), 32'd0);
        flush = 1'b0;
        ready = 1'b1;
        push(0, 16'h0003, 8'h5A);
        drain("t4_drain");
        chk("t4_count2", 32'(cnt), 32'd1);

        // underflow: flag forced high during FETCH
        chk("t5_pre", 32'(uflow), 32'd0);
        tick();
        push(1, 16'h0007, 8'h33);
        tick();
        chk("t5_fetch", 32'(rd), 32'd1);
        force_empty = 1'b1;
        tick();
        force_empty = 1'b0;
        chk("t5_set", 32'(uflow), 32'd1);
        drain("t5_drain");
        repeat (3) tick();
        chk("t5_sticky", 32'(uflow), 32'd1);
        flush = 1'b1;
        tick();
        chk("t5_clear", 32'(uflow), 32'd0);
        flush = 1'b0;
        tick();

        // async reset while in SEND
        ready = 1'b0;
        push(2, 16'h4242, 0);
        wait_valid("t6_valid");
        chk("t6_count_pre", 32'(cnt), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", 32'(valid), 32'd0);
        chk("t6_byte", 32'(obyte), 32'd0);
        chk("t6_rd", 32'(rd), 32'd0);
        chk("t6_count", 32'(cnt), 32'd0);
        chk("t6_uflow", 32'(uflow), 32'd0);
        chk("t6_idle", 32'(idle), 32'(empty));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        tick();
        push(0, 16'h0006, 8'h99);
        drain("t6_drain");
        chk("t6_count2", 32'(cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
